// File: rtl/mdio_dri_if.sv
// Sequencer/pad-side bundle for the Clause-22 MDIO master.
// The slave modport is the MDIO master block; the master modport is its environment.
interface mdio_dri_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;

  logic              op_exec;
  logic              op_rh_wl;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wr_data;
  logic              op_done;
  logic [DATA_W-1:0] op_rd_data;
  logic              op_rd_ack;
  logic              eth_mdc;
  logic              mdio_o;
  logic              mdio_oe;
  logic              mdio_i;

  modport slave (
    input  op_exec, op_rh_wl, op_addr, op_wr_data, mdio_i,
    output op_done, op_rd_data, op_rd_ack, eth_mdc, mdio_o, mdio_oe
  );

  modport master (
    output op_exec, op_rh_wl, op_addr, op_wr_data, mdio_i,
    input  op_done, op_rd_data, op_rd_ack, eth_mdc, mdio_o, mdio_oe
  );
endinterface

// File: rtl/mdio_dri.sv
// Clause-22 MDIO master: runs one 64-bit read/write frame per op_exec pulse,
// generating MDC and serialising MDIO; read data/ack are returned with op_done.
module mdio_dri #(
  parameter logic [4:0] PHY_ADDR = 5'b00001,
  parameter logic [7:0] MDC_HALF = 8'd25
) (
  input  logic       clk,
  input  logic       rst_n,
  mdio_dri_if.slave  bus
);
  localparam int unsigned FRAME_W = 64;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned PH_W    = 8;
  localparam int unsigned DATA_W  = 16;

  localparam logic [PH_W-1:0]  PH_LAST  = MDC_HALF - PH_W'(1);
  localparam logic [BIT_W-1:0] BIT_TA1  = BIT_W'(47);
  localparam logic [BIT_W-1:0] BIT_DATA = BIT_W'(48);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(63);
  localparam logic [BIT_W-1:0] BIT_RDZ  = BIT_W'(46);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              r_state;
  logic [PH_W-1:0]     r_phase;
  logic [BIT_W-1:0]    r_bit;
  logic                r_hi;
  logic                r_rd;
  logic [FRAME_W-1:0]  r_frame;
  logic [DATA_W-1:0]   r_shift;
  logic                r_ta;
  logic                r_done;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_ack;
  logic                r_mdc;
  logic                r_mdo;
  logic                r_oe;

  logic [FRAME_W-1:0]  w_frame;
  logic [BIT_W-1:0]    w_bit_nx;
  logic                w_oe_nx;

  // Whole frame, bit 0 at the MSB; read TA/data slots are ones (line released).
  assign w_frame = {32'hFFFF_FFFF, 2'b01,
                    (bus.op_rh_wl ? 2'b10 : 2'b01),
                    PHY_ADDR, bus.op_addr,
                    (bus.op_rh_wl ? 2'b11 : 2'b10),
                    (bus.op_rh_wl ? 16'hFFFF : bus.op_wr_data)};

  assign w_bit_nx = r_bit + BIT_W'(1);
  assign w_oe_nx  = !r_rd || (w_bit_nx < BIT_RDZ);

  assign bus.op_done    = r_done;
  assign bus.op_rd_data = r_rd_data;
  assign bus.op_rd_ack  = r_rd_ack;
  assign bus.eth_mdc    = r_mdc;
  assign bus.mdio_o     = r_mdo;
  assign bus.mdio_oe    = r_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_bit     <= '0;
      r_hi      <= 1'b0;
      r_rd      <= 1'b0;
      r_frame   <= '0;
      r_shift   <= '0;
      r_ta      <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
      r_rd_ack  <= 1'b0;
      r_mdc     <= 1'b1;
      r_mdo     <= 1'b1;
      r_oe      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_mdc  <= 1'b1;
          r_mdo  <= 1'b1;
          r_oe   <= 1'b0;
          // Outputs are registered, so bit 0's low phase is set up on the accepting edge.
          if (bus.op_exec) begin
            r_state <= S_SHIFT;
            r_rd    <= bus.op_rh_wl;
            r_frame <= w_frame;
            r_bit   <= '0;
            r_phase <= '0;
            r_hi    <= 1'b0;
            r_mdc   <= 1'b0;
            r_mdo   <= w_frame[FRAME_W-1];
            r_oe    <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_phase != PH_LAST) begin
            r_phase <= r_phase + PH_W'(1);
          end else begin
            r_phase <= '0;
            if (!r_hi) begin
              // MDC rising edge: sample the PHY.
              r_hi  <= 1'b1;
              r_mdc <= 1'b1;
              if (r_bit == BIT_TA1) r_ta <= bus.mdio_i;
              if (r_bit >= BIT_DATA) r_shift <= {r_shift[DATA_W-2:0], bus.mdio_i};
            end else if (r_bit == BIT_LAST) begin
              r_state <= S_DONE;
              r_hi    <= 1'b0;
              r_bit   <= '0;
              r_mdc   <= 1'b1;
              r_mdo   <= 1'b1;
              r_oe    <= 1'b0;
              r_done  <= 1'b1;
              if (r_rd) begin
                r_rd_data <= r_shift;
                r_rd_ack  <= r_ta;
              end else begin
                r_rd_ack  <= 1'b0;
              end
            end else begin
              r_bit <= w_bit_nx;
              r_hi  <= 1'b0;
              r_mdc <= 1'b0;
              r_mdo <= r_frame[BIT_LAST - w_bit_nx];
              r_oe  <= w_oe_nx;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_dri.sv
// Bench for mdio_dri: frame-level reference model with a reactive PHY model,
// one fast-MDC instance (half=2) and one default instance (half=25).
module tb_mdio_dri;
  localparam logic [4:0] PHY = 5'b00001;

  logic clk;
  logic rst_n;
  logic cur_sel;
  logic op_exec;
  logic op_rh_wl;
  logic [4:0] op_addr;
  logic [15:0] op_wr_data;
  logic mdio_i;

  int n_checks;
  int n_pass;
  logic [15:0] exp_rdd [2];
  logic        exp_ack [2];

  mdio_dri_if if0 ();
  mdio_dri_if if1 ();

  assign if0.op_exec    = op_exec & ~cur_sel;
  assign if1.op_exec    = op_exec & cur_sel;
  assign if0.op_rh_wl   = op_rh_wl;
  assign if1.op_rh_wl   = op_rh_wl;
  assign if0.op_addr    = op_addr;
  assign if1.op_addr    = op_addr;
  assign if0.op_wr_data = op_wr_data;
  assign if1.op_wr_data = op_wr_data;
  assign if0.mdio_i     = mdio_i;
  assign if1.mdio_i     = mdio_i;

  mdio_dri #(.PHY_ADDR(5'b00001), .MDC_HALF(8'd2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mdio_dri u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete frame on DUT sel; exN offsets (cycles after acceptance) pulse op_exec.
  task automatic run_frame(input bit sel, input int h, input bit rd, input logic [4:0] addr,
                           input logic [15:0] wd, input bit phy_on, input bit ack_bit,
                           input logic [15:0] pdata, input int ex1, input int ex2,
                           input string nm);
    bit q[$];
    int last, ndone, done_o, mdc_err, oe_err, mo_err, edge_err, fe, idx, b;
    logic mdc, mo, moe, dn, prev_mdc, prev_mo, e_mdc, e_oe, e_mo, got_ack;
    logic [15:0] got_rdd;
    repeat (32) q.push_back(1'b1);
    q.push_back(1'b0); q.push_back(1'b1);
    if (rd) begin q.push_back(1'b1); q.push_back(1'b0); end
    else    begin q.push_back(1'b0); q.push_back(1'b1); end
    for (int i = 4; i >= 0; i--) q.push_back(PHY[i]);
    for (int i = 4; i >= 0; i--) q.push_back(addr[i]);
    if (rd) begin q.push_back(1'b1); q.push_back(1'b1); end
    else    begin q.push_back(1'b1); q.push_back(1'b0); end
    for (int i = 15; i >= 0; i--) q.push_back(rd ? 1'b1 : wd[i]);
    if (rd) begin
      exp_ack[sel] = phy_on ? ack_bit : 1'b1;
      exp_rdd[sel] = phy_on ? pdata : 16'hFFFF;
    end else begin
      exp_ack[sel] = 1'b0;
    end

    cur_sel = sel; op_rh_wl = rd; op_addr = addr; op_wr_data = wd; op_exec = 1'b1;
    @(posedge clk); #1;
    op_exec = 1'b0; op_rh_wl = ~rd; op_addr = ~addr; op_wr_data = ~wd;
    last = 128 * h + 1;
    ndone = 0; done_o = -1; mdc_err = 0; oe_err = 0; mo_err = 0; edge_err = 0; fe = 0;
    prev_mdc = 1'b1; prev_mo = 1'b1; got_ack = 1'bx; got_rdd = 'x;
    for (int o = 1; o <= last; o++) begin
      mdc = sel ? if1.eth_mdc : if0.eth_mdc;
      mo  = sel ? if1.mdio_o  : if0.mdio_o;
      moe = sel ? if1.mdio_oe : if0.mdio_oe;
      dn  = sel ? if1.op_done : if0.op_done;
      idx = o - 1;
      if (o == last) begin
        e_mdc = 1'b1; e_oe = 1'b0; e_mo = 1'b1;
      end else begin
        b = idx / (2 * h);
        e_mdc = ((idx % (2 * h)) >= h);
        e_oe  = rd ? (b < 46) : 1'b1;
        e_mo  = q[b];
      end
      if (mdc !== e_mdc) mdc_err++;
      if (moe !== e_oe) oe_err++;
      if ((e_oe || o == last) && mo !== e_mo) mo_err++;
      if (o < last && mo !== prev_mo && !(prev_mdc === 1'b1 && mdc === 1'b0)) edge_err++;
      if (dn === 1'b1) begin
        ndone++; done_o = o;
        got_rdd = sel ? if1.op_rd_data : if0.op_rd_data;
        got_ack = sel ? if1.op_rd_ack  : if0.op_rd_ack;
      end
      // PHY reacts to each MDC falling edge.
      if (prev_mdc === 1'b1 && mdc === 1'b0) begin
        if (rd && phy_on)
          mdio_i = (fe == 47) ? ack_bit : ((fe >= 48) ? pdata[63 - fe] : 1'b1);
        fe++;
      end
      if (o == last) mdio_i = 1'b1;
      op_exec = (o == ex1 || o == ex2);
      prev_mdc = mdc; prev_mo = mo;
      @(posedge clk); #1;
    end
    op_exec = 1'b0;

    n_checks++; if (ndone !== 1) $display("FAIL %s done_count got %0d want 1", nm, ndone); else n_pass++;
    n_checks++; if (done_o !== last) $display("FAIL %s done_cycle got T+%0d want T+%0d", nm, done_o, last); else n_pass++;
    n_checks++; if (got_ack !== exp_ack[sel]) $display("FAIL %s rd_ack got %b want %b", nm, got_ack, exp_ack[sel]); else n_pass++;
    n_checks++; if (got_rdd !== exp_rdd[sel]) $display("FAIL %s rd_data got %h want %h", nm, got_rdd, exp_rdd[sel]); else n_pass++;
    n_checks++; if (mdc_err !== 0) $display("FAIL %s mdc_wave got %0d bad cycles want 0", nm, mdc_err); else n_pass++;
    n_checks++; if (oe_err !== 0) $display("FAIL %s mdio_oe got %0d bad cycles want 0", nm, oe_err); else n_pass++;
    n_checks++; if (mo_err !== 0) $display("FAIL %s mdio_o_bits got %0d bad cycles want 0", nm, mo_err); else n_pass++;
    n_checks++; if (edge_err !== 0) $display("FAIL %s mdio_o_timing got %0d off-edge changes want 0", nm, edge_err); else n_pass++;
    dn  = sel ? if1.op_done : if0.op_done;
    mdc = sel ? if1.eth_mdc : if0.eth_mdc;
    moe = sel ? if1.mdio_oe : if0.mdio_oe;
    n_checks++;
    if ({dn, mdc, moe} !== 3'b010) $display("FAIL %s idle_after_done got done/mdc/oe=%b want 010", nm, {dn, mdc, moe});
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({if0.op_done, if0.op_rd_data, if0.op_rd_ack, if0.eth_mdc, if0.mdio_o, if0.mdio_oe} !== {1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL reset_dut0 got %b want 0_0000_0110", {if0.op_done, if0.op_rd_data, if0.op_rd_ack, if0.eth_mdc, if0.mdio_o, if0.mdio_oe});
    else n_pass++;
    n_checks++;
    if ({if1.op_done, if1.op_rd_data, if1.op_rd_ack, if1.eth_mdc, if1.mdio_o, if1.mdio_oe} !== {1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL reset_dut1 got %b want 0_0000_0110", {if1.op_done, if1.op_rd_data, if1.op_rd_ack, if1.eth_mdc, if1.mdio_o, if1.mdio_oe});
    else n_pass++;
  endtask

  task automatic test_default_mdc();
    run_frame(1'b1, 25, 1'b0, 5'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, -1, -1, "mdc25_write");
  endtask

  task automatic test_write();
    run_frame(1'b0, 2, 1'b0, 5'd0, 16'h9140, 1'b0, 1'b0, 16'h0, -1, -1, "write_9140");
  endtask

  task automatic test_read();
    run_frame(1'b0, 2, 1'b1, 5'd1, 16'h0, 1'b1, 1'b0, 16'h796D, -1, -1, "read_796d");
  endtask

  task automatic test_no_ack();
    run_frame(1'b0, 2, 1'b1, 5'd2, 16'h0, 1'b0, 1'b0, 16'h0, -1, -1, "read_noack");
    run_frame(1'b0, 2, 1'b0, 5'd3, 16'h1234, 1'b0, 1'b0, 16'h0, -1, -1, "write_after_noack");
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 2, 1'b0, 5'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, 41, 257, "exec_ignored");
    run_frame(1'b0, 2, 1'b1, 5'($urandom), 16'h0, 1'b1, 1'($urandom), 16'($urandom), -1, -1, "exec_after_done");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++)
      run_frame(1'b0, 2, 1'($urandom), 5'($urandom), 16'($urandom), 1'($urandom),
                1'($urandom), 16'($urandom), -1, -1, "random");
  endtask

  task automatic test_reset_abort();
    logic seen;
    cur_sel = 1'b0; op_rh_wl = 1'b1; op_addr = 5'($urandom); op_exec = 1'b1;
    @(posedge clk); #1;
    op_exec = 1'b0;
    repeat (201) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    exp_rdd[0] = 16'h0; exp_ack[0] = 1'b0; exp_rdd[1] = 16'h0; exp_ack[1] = 1'b0;
    n_checks++;
    if ({if0.op_done, if0.op_rd_data, if0.op_rd_ack, if0.eth_mdc, if0.mdio_o, if0.mdio_oe} !== {1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL abort_reset_values got %b want 0_0000_0110", {if0.op_done, if0.op_rd_data, if0.op_rd_ack, if0.eth_mdc, if0.mdio_o, if0.mdio_oe});
    else n_pass++;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (if0.op_done === 1'b1) seen = 1'b1; end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin @(posedge clk); #1; if (if0.op_done === 1'b1) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL abort_no_done got op_done=1 want 0"); else n_pass++;
    run_frame(1'b0, 2, 1'b1, 5'($urandom), 16'h0, 1'b1, 1'b0, 16'($urandom), -1, -1, "read_after_abort");
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    exp_rdd[0] = 16'h0; exp_ack[0] = 1'b0; exp_rdd[1] = 16'h0; exp_ack[1] = 1'b0;
    rst_n = 1'b0; cur_sel = 1'b0; op_exec = 1'b0; op_rh_wl = 1'b0;
    op_addr = 5'd0; op_wr_data = 16'h0; mdio_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_default_mdc();
    test_write();
    test_read();
    test_no_ack();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mdio_dri.md
Name: mdio_dri

Overview:
Clause-22 MDIO management master and bit-level serialiser. It executes one register operation per `op_exec` pulse from the MDIO control/sequencer block, drives MDC/MDIO to the external PHY, and returns `op_done`, `op_rd_data` and `op_rd_ack`. It sits between the sequencer and the PHY pins. Tri-state resolution (`mdio_o`, `mdio_oe`, `mdio_i`) happens in the top-level pad wrapper.

Parameters:
PHY_ADDR, 5'b00001, PHY address placed in the PHYAD field of every frame
MDC_HALF, 8'd25, clk cycles per MDC half-period (MDC period = 2*MDC_HALF clk); legal range 2..255

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
op_exec  in  1  single-cycle start pulse
op_rh_wl  in  1  1 = read, 0 = write
op_addr  in  5  PHY register address (REGAD)
op_wr_data  in  16  write data
op_done  out  1  single-cycle pulse, operation complete
op_rd_data  out  16  read data, valid from op_done
op_rd_ack  out  1  0 = PHY acknowledged read (TA bit 1 low); 1 = no response
eth_mdc  out  1  management clock to PHY
mdio_o  out  1  MDIO output value
mdio_oe  out  1  MDIO output enable (1 = master drives)
mdio_i  in  1  MDIO pin input

Behaviour:
- Reset values (async, all regs): `op_done`=0, `op_rd_data`=16'h0000, `op_rd_ack`=0, `eth_mdc`=1, `mdio_o`=1, `mdio_oe`=0, state IDLE, counters 0.
- States:
  - IDLE: `eth_mdc`=1, `mdio_oe`=0. `op_exec`=1 at edge T latches `op_rh_wl`, `op_addr`, `op_wr_data`. Goes to SHIFT at T+1 with bit index 0 and phase counter 0.
  - SHIFT: serialises frame bits 0..63.
  - DONE: exactly one cycle with `op_done`=1, then IDLE.
- Frame, MSB-first within each field:
  - bits 0–31: preamble, 32 ones.
  - bits 32–33: ST = 01.
  - bits 34–35: OP = 10 for read, 01 for write.
  - bits 36–40: PHY_ADDR.
  - bits 41–45: op_addr.
  - bits 46–47: TA.
  - bits 48–63: data.
- Bit timing:
  - Each bit is a low phase of MDC_HALF clk, then a high phase of MDC_HALF clk.
  - `eth_mdc` falls at the start of each bit. `mdio_o` is updated in the same cycle.
  - Master samples `mdio_i` on the clk edge where `eth_mdc` rises.
- Write frames: `mdio_oe`=1 for bits 0–63. TA is driven 1,0. Data is `op_wr_data[15]` first.
- Read frames:
  - `mdio_oe`=1 for bits 0–45, 0 for bits 46–63.
  - TA bit 47 sample is captured as the ack bit.
  - Bits 48–63 are shifted into a holding register, MSB first.
- Completion:
  - After bit 63's high phase, `eth_mdc`=1, `mdio_oe`=0, `mdio_o`=1, and the block enters DONE.
  - `op_done` is asserted in cycle T+1+128*MDC_HALF.
- Outputs at DONE:
  - Read: `op_rd_data` ← captured word, `op_rd_ack` ← TA bit 47 sample. Both are updated in the same cycle as `op_done` and held until the next read completes.
  - Write: `op_rd_ack` ← 0; `op_rd_data` unchanged.
- Boundary conditions:
  - `op_exec` in SHIFT or DONE is ignored, not queued. Latched fields are unaffected.
  - `op_exec` is accepted again from the first IDLE cycle after DONE.
  - Input changes on `op_rh_wl`, `op_addr`, `op_wr_data` after acceptance have no effect on the current frame.
  - `rst_n` asserted mid-frame: immediate return to reset values. No `op_done` for the aborted operation.
  - No ack (`mdio_i` floating high, pulled up): a read completes normally with `op_rd_ack`=1 and data = whatever was sampled (16'hFFFF when pulled up).
- Counters:
  - Phase counter is 8-bit and wraps at MDC_HALF-1.
  - Bit index is 6-bit, 0..63. No overflow past 63: the block exits SHIFT at 63.

Test Plan:
1. MDC_HALF=2, PHY_ADDR=1. Write `op_addr`=0, `op_wr_data`=16'h9140 → MDIO sequence of 32×1, 01, 01, 00001, 00000, 10, 1001000101000000. `mdio_oe` high for all 64 bits. `op_done` exactly at T+257. `op_rd_ack`=0.
2. Read `op_addr`=1, PHY model drives TA bit 47=0 and data 16'h796D on MDC falling edges → `mdio_oe` drops at bit 46. `op_done` at T+257 with `op_rd_data`=16'h796D, `op_rd_ack`=0.
3. Read with `mdio_i` held 1 (no PHY) → `op_rd_ack`=1, `op_rd_data`=16'hFFFF. Next write → `op_rd_ack`=0, `op_rd_data` still 16'hFFFF.
4. `op_exec` pulsed at bit 10 of a write and again in the DONE cycle → both ignored, exactly one `op_done`. `op_exec` in the cycle after DONE → new frame starts next cycle.
5. `rst_n` low during bit 50 of a read → outputs return to reset values immediately. No `op_done`. A new read after release completes normally.
6. MDC_HALF=25 default → `eth_mdc` period 50 clk, 50% duty. `mdio_o` transitions only in cycles where `eth_mdc` falls.
